// File: rtl/obi_amo_engine.sv
// obi_amo_engine: OBI atomics engine placed between one manager port and one
// non-atomic subordinate. LR/SC and AMO requests become read-modify-write
// sequences; plain requests pass straight through. One transaction in flight.
// Optional feature macro: OBI_AMO_MINMAX_EN builds AMOMIN/AMOMAX/AMOMINU/AMOMAXU.
// Without it those four codes are answered with an error and no access.
module obi_amo_engine #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned IdWidth   = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    // manager A channel
    input  logic                   mgr_req_i,
    output logic                   mgr_gnt_o,
    input  logic [AddrWidth-1:0]   mgr_addr_i,
    input  logic                   mgr_we_i,
    input  logic [DataWidth/8-1:0] mgr_be_i,
    input  logic [DataWidth-1:0]   mgr_wdata_i,
    input  logic [IdWidth-1:0]     mgr_aid_i,
    input  logic [5:0]             mgr_atop_i,
    // manager R channel
    output logic                   mgr_rvalid_o,
    output logic [DataWidth-1:0]   mgr_rdata_o,
    output logic [IdWidth-1:0]     mgr_rid_o,
    output logic                   mgr_err_o,
    // subordinate A channel
    output logic                   sbr_req_o,
    input  logic                   sbr_gnt_i,
    output logic [AddrWidth-1:0]   sbr_addr_o,
    output logic                   sbr_we_o,
    output logic [DataWidth/8-1:0] sbr_be_o,
    output logic [DataWidth-1:0]   sbr_wdata_o,
    output logic [IdWidth-1:0]     sbr_aid_o,
    // subordinate R channel
    input  logic                   sbr_rvalid_i,
    input  logic [DataWidth-1:0]   sbr_rdata_i,
    input  logic [IdWidth-1:0]     sbr_rid_i,
    input  logic                   sbr_err_i
);

    localparam int unsigned BeWidth   = DataWidth / 8;
    localparam int unsigned OffsWidth = $clog2(BeWidth);
    localparam int unsigned WordWidth = AddrWidth - OffsWidth;
    localparam int          NumIds    = 2 ** IdWidth;

    // obi_atop_e encoding
    localparam logic [5:0] ATOP_NONE    = 6'h00;
    localparam logic [5:0] ATOP_AMOADD  = 6'h20;
    localparam logic [5:0] ATOP_AMOSWAP = 6'h21;
    localparam logic [5:0] ATOP_LR      = 6'h22;
    localparam logic [5:0] ATOP_SC      = 6'h23;
    localparam logic [5:0] ATOP_AMOXOR  = 6'h24;
    localparam logic [5:0] ATOP_AMOOR   = 6'h28;
    localparam logic [5:0] ATOP_AMOAND  = 6'h2C;
    localparam logic [5:0] ATOP_AMOMIN  = 6'h30;
    localparam logic [5:0] ATOP_AMOMAX  = 6'h34;
    localparam logic [5:0] ATOP_AMOMINU = 6'h38;
    localparam logic [5:0] ATOP_AMOMAXU = 6'h3C;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PASS_R   = 3'd1,
        AMO_RD   = 3'd2,
        AMO_RD_R = 3'd3,
        AMO_WR   = 3'd4,
        AMO_WR_R = 3'd5,
        RESP     = 3'd6
    } state_e;

    // True for every atomic code this build can execute (plain requests excluded).
    function automatic logic atop_supported(input logic [5:0] atop);
        logic ok;
        case (atop)
            ATOP_AMOSWAP, ATOP_AMOADD, ATOP_AMOXOR, ATOP_AMOAND, ATOP_AMOOR,
            ATOP_LR, ATOP_SC: ok = 1'b1;
`ifdef OBI_AMO_MINMAX_EN
            ATOP_AMOMIN, ATOP_AMOMAX, ATOP_AMOMINU, ATOP_AMOMAXU: ok = 1'b1;
`endif
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Value to store for an AMO, given the old memory word and the operand.
    function automatic logic [DataWidth-1:0] amo_result(
        input logic [5:0]           atop,
        input logic [DataWidth-1:0] old_val,
        input logic [DataWidth-1:0] operand
    );
        logic [DataWidth-1:0] res;
        case (atop)
            ATOP_AMOSWAP: res = operand;
            ATOP_AMOADD:  res = old_val + operand;
            ATOP_AMOXOR:  res = old_val ^ operand;
            ATOP_AMOAND:  res = old_val & operand;
            ATOP_AMOOR:   res = old_val | operand;
`ifdef OBI_AMO_MINMAX_EN
            ATOP_AMOMIN:  res = ($signed(old_val) < $signed(operand)) ? old_val : operand;
            ATOP_AMOMAX:  res = ($signed(old_val) > $signed(operand)) ? old_val : operand;
            ATOP_AMOMINU: res = (old_val < operand) ? old_val : operand;
            ATOP_AMOMAXU: res = (old_val > operand) ? old_val : operand;
`endif
            default:      res = old_val;
        endcase
        return res;
    endfunction

    state_e                 state_r;
    state_e                 state_next_s;

    logic [AddrWidth-1:0]   addr_r;
    logic [BeWidth-1:0]     be_r;
    logic [DataWidth-1:0]   operand_r;
    logic [DataWidth-1:0]   wdata_r;
    logic [IdWidth-1:0]     aid_r;
    logic [5:0]             atop_r;
    logic [DataWidth-1:0]   resp_data_r;
    logic                   resp_err_r;

    logic                   resv_valid_r [NumIds];
    logic [WordWidth-1:0]   resv_addr_r  [NumIds];

    logic                   is_plain_s;
    logic                   sc_hit_s;
    logic                   sc_grant_s;
    logic                   lr_set_s;
    logic                   inv_s;
    logic [WordWidth-1:0]   inv_word_s;
    logic                   unused_rid_s;

    // Only one access is ever outstanding, so the returned ID carries no information.
    assign unused_rid_s = ^sbr_rid_i;

    assign is_plain_s = (mgr_atop_i == ATOP_NONE);
    assign sc_hit_s   = resv_valid_r[mgr_aid_i] &&
                        (resv_addr_r[mgr_aid_i] == mgr_addr_i[AddrWidth-1:OffsWidth]);
    assign sc_grant_s = (state_r == IDLE) && mgr_gnt_o && (mgr_atop_i == ATOP_SC);
    assign lr_set_s   = (state_r == AMO_RD_R) && sbr_rvalid_i && !sbr_err_i && (atop_r == ATOP_LR);
    // Every granted write, whatever its origin, shows up on the subordinate port.
    assign inv_s      = sbr_req_o && sbr_we_o && sbr_gnt_i;
    assign inv_word_s = sbr_addr_o[AddrWidth-1:OffsWidth];

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode and all channel outputs; everything is zero while in reset
    always_comb begin
        state_next_s = state_r;
        mgr_gnt_o    = 1'b0;
        mgr_rvalid_o = 1'b0;
        mgr_rdata_o  = '0;
        mgr_rid_o    = '0;
        mgr_err_o    = 1'b0;
        sbr_req_o    = 1'b0;
        sbr_addr_o   = '0;
        sbr_we_o     = 1'b0;
        sbr_be_o     = '0;
        sbr_wdata_o  = '0;
        sbr_aid_o    = '0;
        if (rst_i) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (mgr_req_i && is_plain_s) begin
                        sbr_req_o   = 1'b1;
                        sbr_addr_o  = mgr_addr_i;
                        sbr_we_o    = mgr_we_i;
                        sbr_be_o    = mgr_be_i;
                        sbr_wdata_o = mgr_wdata_i;
                        sbr_aid_o   = mgr_aid_i;
                        mgr_gnt_o   = sbr_gnt_i;
                        if (sbr_gnt_i) begin
                            state_next_s = PASS_R;
                        end else begin
                            state_next_s = IDLE;
                        end
                    end else if (mgr_req_i) begin
                        mgr_gnt_o = 1'b1;
                        if (!atop_supported(mgr_atop_i)) begin
                            state_next_s = RESP;
                        end else if (mgr_atop_i == ATOP_SC) begin
                            state_next_s = sc_hit_s ? AMO_WR : RESP;
                        end else begin
                            state_next_s = AMO_RD;
                        end
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                PASS_R: begin
                    mgr_rvalid_o = sbr_rvalid_i;
                    mgr_rdata_o  = sbr_rdata_i;
                    mgr_err_o    = sbr_err_i;
                    mgr_rid_o    = aid_r;
                    if (sbr_rvalid_i) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = PASS_R;
                    end
                end
                AMO_RD: begin
                    sbr_req_o  = 1'b1;
                    sbr_addr_o = addr_r;
                    sbr_be_o   = be_r;
                    sbr_aid_o  = aid_r;
                    if (sbr_gnt_i) begin
                        state_next_s = AMO_RD_R;
                    end else begin
                        state_next_s = AMO_RD;
                    end
                end
                AMO_RD_R: begin
                    if (!sbr_rvalid_i) begin
                        state_next_s = AMO_RD_R;
                    end else if (sbr_err_i || (atop_r == ATOP_LR)) begin
                        state_next_s = RESP;
                    end else begin
                        state_next_s = AMO_WR;
                    end
                end
                AMO_WR: begin
                    sbr_req_o   = 1'b1;
                    sbr_addr_o  = addr_r;
                    sbr_we_o    = 1'b1;
                    sbr_be_o    = be_r;
                    sbr_wdata_o = wdata_r;
                    sbr_aid_o   = aid_r;
                    if (sbr_gnt_i) begin
                        state_next_s = AMO_WR_R;
                    end else begin
                        state_next_s = AMO_WR;
                    end
                end
                AMO_WR_R: begin
                    if (sbr_rvalid_i) begin
                        state_next_s = RESP;
                    end else begin
                        state_next_s = AMO_WR_R;
                    end
                end
                RESP: begin
                    mgr_rvalid_o = 1'b1;
                    mgr_rdata_o  = resp_data_r;
                    mgr_err_o    = resp_err_r;
                    mgr_rid_o    = aid_r;
                    state_next_s = IDLE;
                end
                default: begin
                    state_next_s = IDLE;
                end
            endcase
        end
    end

    // Capture the accepted request and carry read data / response status through the sequence
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_r      <= '0;
            be_r        <= '0;
            operand_r   <= '0;
            wdata_r     <= '0;
            aid_r       <= '0;
            atop_r      <= 6'h00;
            resp_data_r <= '0;
            resp_err_r  <= 1'b0;
        end else if ((state_r == IDLE) && mgr_gnt_o) begin
            addr_r    <= mgr_addr_i;
            be_r      <= mgr_be_i;
            operand_r <= mgr_wdata_i;
            wdata_r   <= mgr_wdata_i;
            aid_r     <= mgr_aid_i;
            atop_r    <= mgr_atop_i;
            if (is_plain_s) begin
                resp_data_r <= '0;
                resp_err_r  <= 1'b0;
            end else if (!atop_supported(mgr_atop_i)) begin
                resp_data_r <= '0;
                resp_err_r  <= 1'b1;
            end else if ((mgr_atop_i == ATOP_SC) && !sc_hit_s) begin
                resp_data_r <= {{(DataWidth-1){1'b0}}, 1'b1};
                resp_err_r  <= 1'b0;
            end else begin
                resp_data_r <= '0;
                resp_err_r  <= 1'b0;
            end
        end else if ((state_r == AMO_RD_R) && sbr_rvalid_i) begin
            resp_data_r <= sbr_rdata_i;
            resp_err_r  <= sbr_err_i;
            wdata_r     <= amo_result(atop_r, sbr_rdata_i, operand_r);
        end else if ((state_r == AMO_WR_R) && sbr_rvalid_i) begin
            resp_err_r  <= sbr_err_i;
        end
    end

    // Reservation table: set by a clean LR, dropped by SC of the same ID or by any write to the word
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumIds; i++) begin
                resv_valid_r[i] <= 1'b0;
                resv_addr_r[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NumIds; i++) begin
                if (lr_set_s && (aid_r == IdWidth'(i))) begin
                    // a write to the same word in the same cycle wins over the new reservation
                    resv_valid_r[i] <= !(inv_s && (inv_word_s == addr_r[AddrWidth-1:OffsWidth]));
                    resv_addr_r[i]  <= addr_r[AddrWidth-1:OffsWidth];
                end else if (inv_s && (resv_addr_r[i] == inv_word_s)) begin
                    resv_valid_r[i] <= 1'b0;
                end else if (sc_grant_s && (mgr_aid_i == IdWidth'(i))) begin
                    resv_valid_r[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_obi_amo_engine.sv
// Directed testbench for obi_amo_engine with a zero-wait SRAM-like subordinate.
// Expected values are hand-computed constants.
module tb_obi_amo_engine;

    localparam logic [5:0] A_NONE = 6'h00;
    localparam logic [5:0] A_ADD  = 6'h20;
    localparam logic [5:0] A_SWAP = 6'h21;
    localparam logic [5:0] A_LR   = 6'h22;
    localparam logic [5:0] A_SC   = 6'h23;
    localparam logic [5:0] A_MAX  = 6'h34;

    logic        clk;
    logic        rst;
    logic        mgr_req;
    logic        mgr_gnt_o;
    logic [31:0] mgr_addr;
    logic        mgr_we;
    logic [3:0]  mgr_be;
    logic [31:0] mgr_wdata;
    logic [0:0]  mgr_aid;
    logic [5:0]  mgr_atop;
    logic        mgr_rvalid_o;
    logic [31:0] mgr_rdata_o;
    logic [0:0]  mgr_rid_o;
    logic        mgr_err_o;
    logic        sbr_req_o;
    logic        sbr_gnt;
    logic [31:0] sbr_addr_o;
    logic        sbr_we_o;
    logic [3:0]  sbr_be_o;
    logic [31:0] sbr_wdata_o;
    logic [0:0]  sbr_aid_o;
    logic        sbr_rvalid;
    logic [31:0] sbr_rdata;
    logic [0:0]  sbr_rid;
    logic        sbr_err;

    logic        err_rd;
    int          wr_count;
    logic [31:0] mem [0:255];
    logic [7:0]  mem_idx;

    int n_checks;
    int n_errors;

    obi_amo_engine dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .mgr_req_i    (mgr_req),
        .mgr_gnt_o    (mgr_gnt_o),
        .mgr_addr_i   (mgr_addr),
        .mgr_we_i     (mgr_we),
        .mgr_be_i     (mgr_be),
        .mgr_wdata_i  (mgr_wdata),
        .mgr_aid_i    (mgr_aid),
        .mgr_atop_i   (mgr_atop),
        .mgr_rvalid_o (mgr_rvalid_o),
        .mgr_rdata_o  (mgr_rdata_o),
        .mgr_rid_o    (mgr_rid_o),
        .mgr_err_o    (mgr_err_o),
        .sbr_req_o    (sbr_req_o),
        .sbr_gnt_i    (sbr_gnt),
        .sbr_addr_o   (sbr_addr_o),
        .sbr_we_o     (sbr_we_o),
        .sbr_be_o     (sbr_be_o),
        .sbr_wdata_o  (sbr_wdata_o),
        .sbr_aid_o    (sbr_aid_o),
        .sbr_rvalid_i (sbr_rvalid),
        .sbr_rdata_i  (sbr_rdata),
        .sbr_rid_i    (sbr_rid),
        .sbr_err_i    (sbr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_idx = sbr_addr_o[9:2];

    // Zero-wait subordinate memory: response one cycle after each granted request
    always @(posedge clk) begin
        if (rst) begin
            sbr_rvalid <= 1'b0;
            sbr_rdata  <= 32'h0;
            sbr_err    <= 1'b0;
            sbr_rid    <= 1'b0;
        end else begin
            sbr_rvalid <= 1'b0;
            sbr_err    <= 1'b0;
            if (sbr_req_o && sbr_gnt) begin
                sbr_rvalid <= 1'b1;
                sbr_rid    <= sbr_aid_o;
                if (sbr_we_o) begin
                    for (int b = 0; b < 4; b++) begin
                        if (sbr_be_o[b]) mem[mem_idx][8*b +: 8] <= sbr_wdata_o[8*b +: 8];
                    end
                    wr_count  <= wr_count + 1;
                    sbr_rdata <= 32'h0;
                end else begin
                    sbr_rdata <= mem[mem_idx];
                    sbr_err   <= err_rd;
                end
            end
        end
    end

    // Compare one observed value against its expected value
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // One complete manager transaction; lat = cycles from manager grant to rvalid
    task automatic xact(input string tag, input logic [5:0] atop, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [0:0] aid,
                        output logic [31:0] rdata, output logic err, output logic [0:0] rid,
                        output int lat);
        int n;
        @(negedge clk);
        mgr_req = 1'b1; mgr_atop = atop; mgr_we = we; mgr_addr = addr;
        mgr_wdata = wdata; mgr_aid = aid; mgr_be = 4'hF;
        #1;
        n = 0;
        while (!mgr_gnt_o && n < 20) begin
            @(negedge clk); #1; n++;
        end
        rdata = 32'h0; err = 1'b0; rid = 1'b0; lat = 0;
        if (!mgr_gnt_o) begin
            check({tag, "_gnt_timeout"}, {31'h0, mgr_gnt_o}, 32'h1);
            mgr_req = 1'b0;
        end else begin
            @(posedge clk);
            #1 mgr_req = 1'b0;
            n = 0;
            while (n < 50) begin
                @(negedge clk); lat++; n++;
                if (mgr_rvalid_o) break;
            end
            if (!mgr_rvalid_o) begin
                check({tag, "_rvalid_timeout"}, {31'h0, mgr_rvalid_o}, 32'h1);
            end else begin
                rdata = mgr_rdata_o; err = mgr_err_o; rid = mgr_rid_o;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [0:0]  rid;
        int          lat;
        int          wc0;
        int          n;
        logic        no_resp;

        n_checks = 0; n_errors = 0; wr_count = 0;
        rst = 1'b1; mgr_req = 1'b0; mgr_addr = 32'h0; mgr_we = 1'b0; mgr_be = 4'h0;
        mgr_wdata = 32'h0; mgr_aid = 1'b0; mgr_atop = 6'h00; sbr_gnt = 1'b1; err_rd = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_gnt", {31'h0, mgr_gnt_o}, 32'h0);
        check("rst_rvalid", {31'h0, mgr_rvalid_o}, 32'h0);
        check("rst_sbr_req", {31'h0, sbr_req_o}, 32'h0);
        rst = 1'b0;

        // plain write with a stalled subordinate grant: manager grant must follow it
        @(negedge clk);
        sbr_gnt = 1'b0;
        mgr_req = 1'b1; mgr_atop = A_NONE; mgr_we = 1'b1; mgr_addr = 32'h100;
        mgr_wdata = 32'hDEADBEEF; mgr_be = 4'hF; mgr_aid = 1'b0;
        #1;
        check("pt_gnt_stall", {31'h0, mgr_gnt_o}, 32'h0);
        check("pt_sbr_req", {31'h0, sbr_req_o}, 32'h1);
        check("pt_sbr_addr", sbr_addr_o, 32'h100);
        @(negedge clk);
        sbr_gnt = 1'b1;
        #1;
        check("pt_gnt_follow", {31'h0, mgr_gnt_o}, 32'h1);
        @(posedge clk);
        #1 mgr_req = 1'b0;
        @(negedge clk);
        check("pt_wr_rvalid", {31'h0, mgr_rvalid_o}, 32'h1);
        check("pt_wr_err", {31'h0, mgr_err_o}, 32'h0);

        xact("pt_rd", A_NONE, 1'b0, 32'h100, 32'h0, 1'b0, rd, er, rid, lat);
        check("pt_rd_data", rd, 32'hDEADBEEF);
        check("pt_rd_err", {31'h0, er}, 32'h0);
        check("pt_rd_lat", lat, 32'd1);

        // AMOADD wraps: 0xFFFFFFFF + 2 = 1
        xact("pre_10", A_NONE, 1'b1, 32'h10, 32'hFFFFFFFF, 1'b0, rd, er, rid, lat);
        xact("add", A_ADD, 1'b0, 32'h10, 32'h2, 1'b0, rd, er, rid, lat);
        check("add_old", rd, 32'hFFFFFFFF);
        check("add_err", {31'h0, er}, 32'h0);
        check("add_sub_lat", lat - 1, 32'd4);
        xact("add_rb", A_NONE, 1'b0, 32'h10, 32'h0, 1'b0, rd, er, rid, lat);
        check("add_mem", rd, 32'h1);

        // AMOSWAP clean
        xact("swap", A_SWAP, 1'b0, 32'h10, 32'h0000A5A5, 1'b0, rd, er, rid, lat);
        check("swap_old", rd, 32'h1);
        xact("swap_rb", A_NONE, 1'b0, 32'h10, 32'h0, 1'b0, rd, er, rid, lat);
        check("swap_mem", rd, 32'h0000A5A5);

        // LR / SC success then repeated SC failure
        xact("pre_40", A_NONE, 1'b1, 32'h40, 32'h77, 1'b0, rd, er, rid, lat);
        xact("lr0", A_LR, 1'b0, 32'h40, 32'h0, 1'b0, rd, er, rid, lat);
        check("lr0_data", rd, 32'h77);
        check("lr0_sub_lat", lat - 1, 32'd2);
        xact("sc0", A_SC, 1'b0, 32'h40, 32'h5, 1'b0, rd, er, rid, lat);
        check("sc0_data", rd, 32'h0);
        check("sc0_err", {31'h0, er}, 32'h0);
        xact("sc0_rb", A_NONE, 1'b0, 32'h40, 32'h0, 1'b0, rd, er, rid, lat);
        check("sc0_mem", rd, 32'h5);
        wc0 = wr_count;
        xact("sc0_again", A_SC, 1'b0, 32'h40, 32'h6, 1'b0, rd, er, rid, lat);
        check("sc0_again_data", rd, 32'h1);
        check("sc0_again_lat", lat, 32'd1);
        check("sc0_again_nowr", wr_count - wc0, 32'd0);

        // two reservations killed by one plain write
        xact("lr0b", A_LR, 1'b0, 32'h40, 32'h0, 1'b0, rd, er, rid, lat);
        xact("lr1b", A_LR, 1'b0, 32'h40, 32'h0, 1'b1, rd, er, rid, lat);
        check("lr1b_rid", {31'h0, rid}, 32'h1);
        check("lr1b_data", rd, 32'h5);
        xact("inv_wr", A_NONE, 1'b1, 32'h40, 32'h9, 1'b0, rd, er, rid, lat);
        xact("sc0b", A_SC, 1'b0, 32'h40, 32'h11, 1'b0, rd, er, rid, lat);
        check("sc0b_data", rd, 32'h1);
        xact("sc1b", A_SC, 1'b0, 32'h40, 32'h22, 1'b1, rd, er, rid, lat);
        check("sc1b_data", rd, 32'h1);
        check("sc1b_rid", {31'h0, rid}, 32'h1);
        xact("inv_rb", A_NONE, 1'b0, 32'h40, 32'h0, 1'b0, rd, er, rid, lat);
        check("inv_mem", rd, 32'h9);

        // read error aborts the AMO before the write
        err_rd = 1'b1;
        wc0 = wr_count;
        xact("swap_err", A_SWAP, 1'b0, 32'h10, 32'h12345678, 1'b0, rd, er, rid, lat);
        err_rd = 1'b0;
        check("swap_err_err", {31'h0, er}, 32'h1);
        check("swap_err_data", rd, 32'h0000A5A5);
        check("swap_err_nowr", wr_count - wc0, 32'd0);

        // unsupported code
        xact("bad_atop", 6'h3F, 1'b0, 32'h10, 32'h0, 1'b1, rd, er, rid, lat);
        check("bad_err", {31'h0, er}, 32'h1);
        check("bad_data", rd, 32'h0);
        check("bad_rid", {31'h0, rid}, 32'h1);

        // reset while waiting for the AMO write response
        xact("lr1c", A_LR, 1'b0, 32'h80, 32'h0, 1'b1, rd, er, rid, lat);
        @(negedge clk);
        mgr_req = 1'b1; mgr_atop = A_ADD; mgr_we = 1'b0; mgr_addr = 32'h84;
        mgr_wdata = 32'h1; mgr_aid = 1'b0; mgr_be = 4'hF;
        #1;
        check("rmid_gnt", {31'h0, mgr_gnt_o}, 32'h1);
        @(posedge clk);
        #1 mgr_req = 1'b0;
        n = 0;
        while (!(sbr_req_o && sbr_we_o) && n < 20) begin
            @(negedge clk); n++;
        end
        check("rmid_wr_issued", {31'h0, sbr_req_o & sbr_we_o}, 32'h1);
        @(posedge clk);
        #1 rst = 1'b1;
        no_resp = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (mgr_rvalid_o) no_resp = 1'b0;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (mgr_rvalid_o) no_resp = 1'b0;
        end
        check("rmid_no_resp", {31'h0, no_resp}, 32'h1);
        xact("sc1c", A_SC, 1'b0, 32'h80, 32'h33, 1'b1, rd, er, rid, lat);
        check("sc1c_resv_cleared", rd, 32'h1);

        // AMOMAX signed: max(-1, 3) = 3
        xact("pre_20", A_NONE, 1'b1, 32'h20, 32'hFFFFFFFF, 1'b0, rd, er, rid, lat);
        xact("max", A_MAX, 1'b0, 32'h20, 32'h3, 1'b0, rd, er, rid, lat);
`ifdef OBI_AMO_MINMAX_EN
        check("max_old", rd, 32'hFFFFFFFF);
        check("max_err", {31'h0, er}, 32'h0);
        xact("max_rb", A_NONE, 1'b0, 32'h20, 32'h0, 1'b0, rd, er, rid, lat);
        check("max_mem", rd, 32'h3);
`else
        check("max_err", {31'h0, er}, 32'h1);
        check("max_data", rd, 32'h0);
        xact("max_rb", A_NONE, 1'b0, 32'h20, 32'h0, 1'b0, rd, er, rid, lat);
        check("max_mem", rd, 32'hFFFFFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
